// File: rtl/riscvlong_mem_arbiter.sv
// rtl/riscvlong_mem_arbiter.sv - round-robin sharing of one memory port between imem and dmem
// Responses return in order; an ID FIFO records who issued each request so the response val is steered back.
module riscvlong_mem_arbiter #(
  parameter int p_max_outstanding = 4,
  parameter int p_req_msg_sz      = 67,
  parameter int p_resp_msg_sz     = 35,
  localparam int c_ptr_w          = $clog2(p_max_outstanding),
  localparam int c_cnt_w          = c_ptr_w + 1
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [p_req_msg_sz-1:0]  imemreq_msg,
  input  logic                     imemreq_val,
  output logic                     imemreq_rdy,
  output logic [p_resp_msg_sz-1:0] imemresp_msg,
  output logic                     imemresp_val,

  input  logic [p_req_msg_sz-1:0]  dmemreq_msg,
  input  logic                     dmemreq_val,
  output logic                     dmemreq_rdy,
  output logic [p_resp_msg_sz-1:0] dmemresp_msg,
  output logic                     dmemresp_val,

  output logic [p_req_msg_sz-1:0]  memreq_msg,
  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  input  logic [p_resp_msg_sz-1:0] memresp_msg,
  input  logic                     memresp_val,

  output logic [c_cnt_w-1:0]       outstanding,
  output logic                     err_orphan_resp
);

  logic [p_max_outstanding-1:0] r_id_fifo;
  logic [c_ptr_w-1:0]           r_wr_ptr;
  logic [c_ptr_w-1:0]           r_rd_ptr;
  logic [c_cnt_w-1:0]           r_outstanding;
  logic                         r_last_grant;
  logic                         r_err_orphan;

  logic w_full;
  logic w_any_val;
  logic w_sel;
  logic w_fire;
  logic w_busy;
  logic w_pop;
  logic w_orphan;
  logic w_head;

  assign w_full    = (r_outstanding == c_cnt_w'(p_max_outstanding));
  assign w_any_val = imemreq_val | dmemreq_val;

  // Selection ignores memreq_rdy; ID 1 means the data port.
  always_comb begin
    w_sel = 1'b0;
    if (imemreq_val && dmemreq_val) w_sel = ~r_last_grant;
    else if (dmemreq_val)           w_sel = 1'b1;
  end

  assign memreq_msg  = w_sel ? dmemreq_msg : imemreq_msg;
  assign memreq_val  = w_any_val & ~w_full & ~reset;
  assign imemreq_rdy = ~w_sel & memreq_rdy & ~w_full & ~reset;
  assign dmemreq_rdy =  w_sel & memreq_rdy & ~w_full & ~reset;
  assign w_fire      = memreq_val & memreq_rdy;

  assign w_busy   = (r_outstanding != '0);
  assign w_head   = r_id_fifo[r_rd_ptr];
  assign w_pop    = memresp_val & w_busy & ~reset;
  assign w_orphan = memresp_val & ~w_busy & ~reset;

  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = w_pop & ~w_head;
  assign dmemresp_val = w_pop &  w_head;

  assign outstanding     = r_outstanding;
  assign err_orphan_resp = r_err_orphan;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_fifo     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
      r_last_grant  <= 1'b1;
      r_err_orphan  <= 1'b0;
    end else begin
      if (w_fire) begin
        r_id_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
        r_last_grant        <= w_sel;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_fire && !w_pop)      r_outstanding <= r_outstanding + c_cnt_w'(1);
      else if (!w_fire && w_pop) r_outstanding <= r_outstanding - c_cnt_w'(1);
      if (w_orphan) r_err_orphan <= 1'b1;
    end
  end

endmodule
